// File: rtl/bfis_ctrl_pkg.sv
// Shared definitions for the BFIS query controller: FSM state encoding,
// default geometry constants and the k clamping helper.
package bfis_ctrl_pkg;

    localparam int unsigned DIM_DEF     = 8;
    localparam int unsigned K_MAX_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        RUN   = 3'd3,
        ABORT = 3'd4,
        DRAIN = 3'd5
    } state_t;

    // A requested k of 0 still asks for one result; anything beyond the
    // buffer depth is limited to the depth.
    function automatic logic [15:0] clamp_k(input logic [15:0] k, input logic [15:0] kmax);
        if (k == '0) begin
            return 16'd1;
        end
        if (k > kmax) begin
            return kmax;
        end
        return k;
    endfunction

endpackage

// File: rtl/bfis_query_ctrl_if.sv
// Host-side bundle of the query controller: query-word upload with its
// k / start-vertex configuration, and the result read-back handshake.
//   master : host (drives query words, accepts results)
//   slave  : controller
interface bfis_query_ctrl_if;

    logic        q_valid_in;
    logic        q_ready_out;
    logic [31:0] q_data_in;
    logic [15:0] cfg_k_in;
    logic [31:0] cfg_vertex_in;
    logic        res_valid_out;
    logic        res_ready_in;
    logic [31:0] res_data_out;
    logic        res_last_out;

    modport master (
        output q_valid_in, q_data_in, cfg_k_in, cfg_vertex_in, res_ready_in,
        input  q_ready_out, res_valid_out, res_data_out, res_last_out
    );

    modport slave (
        input  q_valid_in, q_data_in, cfg_k_in, cfg_vertex_in, res_ready_in,
        output q_ready_out, res_valid_out, res_data_out, res_last_out
    );

endinterface

// File: rtl/bfis_result_buf.sv
// Result FIFO for one query: DEPTH x 32 storage with write pointer, read
// pointer and occupancy count. clr_i empties it at the start of a query.
//   clk_in / rst_in : clock, asynchronous active-low reset
//   clr_i           : synchronous flush (wins over write/read)
//   wr_en_i/wr_data_i : push one result
//   rd_en_i         : pop the head entry
//   rd_data_o       : head entry
//   count_o         : number of stored entries
module bfis_result_buf #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         clr_i,
    input  logic                         wr_en_i,
    input  logic [31:0]                  wr_data_i,
    input  logic                         rd_en_i,
    output logic [31:0]                  rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_en_i) begin
                wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (rd_en_i) begin
                rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            end
            if (wr_en_i && !rd_en_i) begin
                cnt_d = cnt_q + 1'b1;
            end else if (rd_en_i && !wr_en_i) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en_i && !clr_i) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign count_o   = cnt_q;

endmodule

// File: rtl/bfis_query_ctrl.sv
// BFIS query controller: collects a DIM-word query from the host, starts
// the search engine, buffers up to k results (with timeout abort) and
// streams them back to the host.
//   clk_in / rst_in       : clock, asynchronous active-low reset
//   host                  : host query/result handshake bundle (slave side)
//   eng_query_out/eng_vertex_out/eng_k_out : engine job description
//   eng_start_out/eng_abort_out : one-cycle engine strobes
//   eng_res_valid_in/eng_res_in/eng_done_in : engine result stream
//   busy_out/state_out/timeout_err_out/overflow_out/queries_done_out : status
module bfis_query_ctrl
    import bfis_ctrl_pkg::*;
#(
    parameter int unsigned DIM     = DIM_DEF,
    parameter int unsigned K_MAX   = K_MAX_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    bfis_query_ctrl_if.slave      host,
    output logic [DIM-1:0][31:0]  eng_query_out,
    output logic [31:0]           eng_vertex_out,
    output logic [15:0]           eng_k_out,
    output logic                  eng_start_out,
    output logic                  eng_abort_out,
    input  logic                  eng_res_valid_in,
    input  logic [31:0]           eng_res_in,
    input  logic                  eng_done_in,
    output logic                  busy_out,
    output logic [2:0]            state_out,
    output logic                  timeout_err_out,
    output logic                  overflow_out,
    output logic [15:0]           queries_done_out
);

    localparam int unsigned IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned RUN_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_W = $clog2(K_MAX + 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     widx_q, widx_d;
    logic [DIM-1:0][31:0] query_q, query_d;
    logic [31:0]          vertex_q, vertex_d;
    logic [15:0]          k_q, k_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic                 tout_q, tout_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          qdone_q, qdone_d;

    logic                 buf_clr, buf_wr, buf_rd;
    logic [31:0]          buf_data;
    logic [CNT_W-1:0]     buf_cnt;
    logic                 q_fire;

    bfis_result_buf #(.DEPTH(K_MAX)) u_buf (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_i     (buf_clr),
        .wr_en_i   (buf_wr),
        .wr_data_i (eng_res_in),
        .rd_en_i   (buf_rd),
        .rd_data_o (buf_data),
        .count_o   (buf_cnt)
    );

    // Gated by reset so every output reads 0 while reset is held.
    assign host.q_ready_out = rst_in && (state_q == IDLE || state_q == LOAD);
    assign q_fire           = host.q_valid_in && host.q_ready_out;

    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        query_d  = query_q;
        vertex_d = vertex_q;
        k_d      = k_q;
        run_d    = run_q;
        tout_d   = tout_q;
        ovf_d    = ovf_q;
        qdone_d  = qdone_q;
        buf_clr  = 1'b0;
        buf_wr   = 1'b0;
        buf_rd   = 1'b0;

        unique case (state_q)
            IDLE, LOAD: begin
                if (q_fire) begin
                    query_d[widx_q] = host.q_data_in;
                    if (state_q == IDLE) begin
                        tout_d = 1'b0;
                        ovf_d  = 1'b0;
                    end
                    if (widx_q == IDX_W'(DIM - 1)) begin
                        k_d      = clamp_k(host.cfg_k_in, 16'(K_MAX));
                        vertex_d = host.cfg_vertex_in;
                        widx_d   = '0;
                        state_d  = ISSUE;
                    end else begin
                        widx_d  = widx_q + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            ISSUE: begin
                buf_clr = 1'b1;
                run_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // A result arriving with done is still captured.
                if (eng_res_valid_in) begin
                    if (16'(buf_cnt) < k_q) begin
                        buf_wr = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (eng_done_in) begin
                    state_d = DRAIN;
                end else if (run_q == RUN_W'(TIMEOUT - 1)) begin
                    state_d = ABORT;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
            ABORT: begin
                tout_d  = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (buf_cnt == '0) begin
                    state_d = IDLE;
                    qdone_d = qdone_q + 16'd1;
                end else if (host.res_ready_in) begin
                    buf_rd = 1'b1;
                    if (buf_cnt == CNT_W'(1)) begin
                        state_d = IDLE;
                        qdone_d = qdone_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            widx_q   <= '0;
            query_q  <= '0;
            vertex_q <= '0;
            k_q      <= '0;
            run_q    <= '0;
            tout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            qdone_q  <= '0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            query_q  <= query_d;
            vertex_q <= vertex_d;
            k_q      <= k_d;
            run_q    <= run_d;
            tout_q   <= tout_d;
            ovf_q    <= ovf_d;
            qdone_q  <= qdone_d;
        end
    end

    assign host.res_valid_out = (state_q == DRAIN) && (buf_cnt != '0);
    assign host.res_data_out  = host.res_valid_out ? buf_data : '0;
    assign host.res_last_out  = host.res_valid_out && (buf_cnt == CNT_W'(1));

    assign eng_query_out    = query_q;
    assign eng_vertex_out   = vertex_q;
    assign eng_k_out        = k_q;
    assign eng_start_out    = (state_q == ISSUE);
    assign eng_abort_out    = (state_q == ABORT);
    assign busy_out         = (state_q != IDLE);
    assign state_out        = state_q;
    assign timeout_err_out  = tout_q;
    assign overflow_out     = ovf_q;
    assign queries_done_out = qdone_q;

endmodule
